// File: rtl/aap_fetch_sequencer.sv
// AAP fetch sequencer: owns the PC, fetches 16-bit words, assembles 16/32-bit instructions for the decoder.
// Optional macro AAP_SLOW_TICK_EN: advance the sequencer only on divider ticks (every DIV_MAX+1 clocks).
module aap_fetch_sequencer #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int DIV_MAX = 217
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            halt_req,
  output logic            halted,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ack,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_word,
  output logic            instr_long,
  output logic [PC_W-1:0] instr_pc,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    ISSUE    = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [PC_W-1:0] pc, next_pc;
  logic [15:0]     lo, hi, next_lo, next_hi;
  logic            is_long, next_long;
  logic            flush_pending, next_flush;
  logic [15:0]     next_count;
  logic            tick;
  logic            fetch_next;
  logic            start_req;

`ifdef AAP_SLOW_TICK_EN
  localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  logic [DIV_W-1:0] div_cnt;

  // Free-running divider; the sequencer advances only on its terminal count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= {DIV_W{1'b0}};
    end else if (div_cnt == DIV_W'(DIV_MAX)) begin
      div_cnt <= {DIV_W{1'b0}};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1'b1);
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV_MAX));
`else
  logic unused_div;
  assign unused_div = DIV_MAX[0];
  assign tick = 1'b1;
`endif

  assign fetch_next = (next_state == FETCH_LO) || (next_state == FETCH_HI);
  // A new memory request starts on entry to a fetch state or right after an ack
  assign start_req  = fetch_next && (((state != FETCH_LO) && (state != FETCH_HI)) || mem_ack);

  // Next-state, PC and instruction assembly
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_lo    = lo;
    next_hi    = hi;
    next_long  = is_long;
    next_flush = flush_pending;
    next_count = instr_count;
    case (state)
      IDLE: begin
        if (redirect_valid) next_pc = redirect_pc;
        else                next_pc = pc;
        if (enable) next_state = halt_req ? HALT : FETCH_LO;
        else        next_state = IDLE;
      end
      FETCH_LO, FETCH_HI: begin
        if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_flush = 1'b1;
        end else begin
          next_pc = pc;
        end
        // The handshake always completes; flushed data is dropped and fetch restarts at the new pc
        if (mem_ack) begin
          if (flush_pending || redirect_valid) begin
            next_flush = 1'b0;
            next_state = FETCH_LO;
          end else if (state == FETCH_LO) begin
            next_lo = mem_rdata;
            if (mem_rdata[15]) begin
              next_state = FETCH_HI;
            end else begin
              next_hi    = 16'h0000;
              next_long  = 1'b0;
              next_state = ISSUE;
            end
          end else begin
            next_hi    = mem_rdata;
            next_long  = 1'b1;
            next_state = ISSUE;
          end
        end else begin
          next_state = state;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          next_count = instr_count + 16'd1;
          if (redirect_valid) next_pc = redirect_pc;
          else                next_pc = pc + (is_long ? PC_W'(2'd2) : PC_W'(1'b1));
          if (halt_req)     next_state = HALT;
          else if (!enable) next_state = IDLE;
          else              next_state = FETCH_LO;
        end else if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_state = FETCH_LO;
        end else begin
          next_state = ISSUE;
        end
      end
      HALT: begin
        if (redirect_valid) next_pc = redirect_pc;
        else                next_pc = pc;
        if (!enable)        next_state = IDLE;
        else if (!halt_req) next_state = FETCH_LO;
        else                next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, PC and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      lo            <= 16'h0000;
      hi            <= 16'h0000;
      is_long       <= 1'b0;
      flush_pending <= 1'b0;
      instr_count   <= 16'h0000;
      mem_req       <= 1'b0;
      mem_addr      <= {PC_W{1'b0}};
      instr_valid   <= 1'b0;
      instr_word    <= 32'h0000_0000;
      instr_long    <= 1'b0;
      instr_pc      <= {PC_W{1'b0}};
      halted        <= 1'b0;
    end else if (tick) begin
      state         <= next_state;
      pc            <= next_pc;
      lo            <= next_lo;
      hi            <= next_hi;
      is_long       <= next_long;
      flush_pending <= next_flush;
      instr_count   <= next_count;
      mem_req       <= fetch_next;
      if (start_req) begin
        mem_addr <= (next_state == FETCH_HI) ? next_pc + PC_W'(1'b1) : next_pc;
      end else begin
        mem_addr <= mem_addr;
      end
      instr_valid   <= (next_state == ISSUE);
      instr_word    <= {next_hi, next_lo};
      instr_long    <= next_long;
      if ((next_state == ISSUE) && (state != ISSUE)) begin
        instr_pc <= next_pc;
      end else begin
        instr_pc <= instr_pc;
      end
      halted        <= (next_state == HALT);
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_aap_fetch_sequencer.sv
// Directed self-checking bench for aap_fetch_sequencer with a latency-programmable memory responder.
module tb_aap_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_word;
  logic        instr_long;
  logic [15:0] instr_pc;
  logic [15:0] instr_count;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [15:0] mem [0:65535];
  int          lat = 0;
  int          wait_cnt = 0;
  logic [15:0] ack_log [0:15];
  int          n_acks = 0;
  logic        saw_pc8 = 1'b0;

  aap_fetch_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .halt_req(halt_req), .halted(halted),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .instr_long(instr_long), .instr_pc(instr_pc), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory responder: acks lat cycles after the request is seen, logs each acked address
  initial begin
    forever begin
      @(negedge clock);
      if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (n_acks < 16) ack_log[n_acks] = mem_addr;
          n_acks++;
          wait_cnt  = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (instr_valid && instr_pc == 16'h0008) saw_pc8 = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clock);
    check(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr);
    for (int i = 0; i < 40 && !(mem_req && mem_addr == addr); i++) @(negedge clock);
    check(tag, {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, addr});
  endtask

  task automatic transfer();
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clock);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held_word;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) & 16'h7FFF;
    mem[0]      = 16'h1234;
    mem[4]      = 16'h8001;
    mem[5]      = 16'hBEEF;
    mem[16'hFFFF] = 16'h8AAA;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_outputs", {mem_req, instr_valid, instr_long, halted}, 32'd0);
    check("rst_addr_pc", {mem_addr, instr_pc}, 32'd0);
    check("rst_word_cnt", instr_word | {16'd0, instr_count}, 32'd0);
    reset = 1'b0;

    // Short instruction at address 0
    enable = 1'b1;
    wait_valid("s1_valid");
    check("s1_word", instr_word, 32'h0000_1234);
    check("s1_long_pc", {15'd0, instr_long, instr_pc}, 32'd0);
    check("s1_cnt_before", {16'd0, instr_count}, 32'd0);
    transfer();
    check("s1_next_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0001});
    check("s1_cnt_after", {16'd0, instr_count}, 32'd1);

    // Long instruction at address 4, with decoder back-pressure
    wait_valid("s2_pre_valid");
    n_acks = 0;
    redirect(16'h0004);
    check("s2_redirect_drop", {31'd0, instr_valid}, 32'd0);
    wait_valid("s2_valid");
    check("s2_word", instr_word, 32'hBEEF_8001);
    check("s2_long_pc", {15'd0, instr_long, instr_pc}, {15'd0, 1'b1, 16'h0004});
    check("s2_reads", {n_acks[7:0], 8'd0, ack_log[0][7:0], ack_log[1][7:0]}, 32'h0200_0405);
    held_word = instr_word;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("s3_hold", {instr_valid, instr_word[30:0]}, {1'b1, held_word[30:0]});
    end
    check("s3_cnt_before", {16'd0, instr_count}, 32'd1);
    transfer();
    check("s3_cnt_after", {16'd0, instr_count}, 32'd2);
    check("s2_next_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0006});
    repeat (4) @(negedge clock);
    check("s3_cnt_once", {16'd0, instr_count}, 32'd2);

    // Redirect while the request at address 8 is outstanding
    lat = 3;
    redirect(16'h0008);
    wait_req("s4_req8", 16'h0008);
    redirect(16'h0100);
    check("s4_addr_stable", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0008});
    wait_req("s4_req100", 16'h0100);
    wait_valid("s4_valid");
    check("s4_pc", {16'd0, instr_pc}, 32'h0000_0100);
    check("s4_no_pc8", {31'd0, saw_pc8}, 32'd0);

    // Long instruction straddling the PC wrap
    lat = 0;
    n_acks = 0;
    redirect(16'hFFFF);
    wait_valid("s5_valid");
    check("s5_word", instr_word, 32'h1234_8AAA);
    check("s5_pc", {15'd0, instr_long, instr_pc}, {15'd0, 1'b1, 16'hFFFF});
    check("s5_reads", {ack_log[0], ack_log[1]}, 32'hFFFF_0000);
    transfer();
    check("s5_next_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0001});

    // Halt requested during a fetch
    halt_req = 1'b1;
    wait_valid("s6_valid");
    check("s6_pc", {15'd0, halted, instr_pc}, 32'h0000_0001);
    transfer();
    check("s6_halted", {halted, mem_req, instr_valid}, 32'd4);
    repeat (3) @(negedge clock);
    check("s6_still_halted", {halted, mem_req}, 32'd2);
    check("s6_cnt", {16'd0, instr_count}, 32'd4);
    mem[2] = 16'h8002;
    lat = 2;
    halt_req = 1'b0;
    @(negedge clock);
    check("s6_resume", {14'd0, halted, mem_req, mem_addr}, {14'd0, 1'b0, 1'b1, 16'h0002});

    // Asynchronous reset in the middle of FETCH_HI
    wait_req("s7_fetch_hi", 16'h0003);
    #2;
    reset = 1'b1;
    lat = 0;
    #1;
    check("s7_rst_ctrl", {mem_req, instr_valid, instr_long, halted}, 32'd0);
    check("s7_rst_addr", {mem_addr, instr_pc}, 32'd0);
    check("s7_rst_word_cnt", instr_word | {16'd0, instr_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("s7_restart_pc", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/aap_fetch_sequencer.md
Name: aap_fetch_sequencer

Overview:
- Sequences instruction fetch for the AAP pipeline.
- Reads 16-bit words from instruction memory over a req/ack handshake and assembles 16- or 32-bit instructions.
- Presents each instruction to the 16-bit decoder over a valid/ready handshake.
- Owns the PC and handles halt, enable and branch redirect. Sits between instruction memory and the decoder stage.

Parameters:
PC_W, 16, PC width in bits; PC is word-addressed and wraps modulo 2^PC_W.
RESET_PC, 0, PC value loaded on reset.
DIV_MAX, 217, tick divider terminal count; used only with AAP_SLOW_TICK_EN.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable
halt_req  in  1  request halt at the next instruction boundary
halted  out  1  high while in HALT
redirect_valid  in  1  branch redirect strobe
redirect_pc  in  PC_W  redirect target
mem_req  out  1  memory read request
mem_addr  out  PC_W  memory word address
mem_rdata  in  16  memory read data, valid with mem_ack
mem_ack  in  1  memory read completion
instr_valid  out  1  instruction available to decoder
instr_ready  in  1  decoder accepts instruction
instr_word  out  32  {hi,lo}; hi=0 for short instructions
instr_long  out  1  instruction is 32-bit
instr_pc  out  PC_W  address of the instruction's low word
instr_count  out  16  count of accepted instructions, wraps

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC; all outputs 0; instr_count=0; flush_pending=0.
- States: IDLE, FETCH_LO, FETCH_HI, ISSUE, HALT.
- IDLE:
  - enable & !halt_req -> FETCH_LO.
  - enable & halt_req -> HALT.
- FETCH_LO:
  - mem_req=1, mem_addr=pc.
  - mem_req and mem_addr stay stable until the mem_ack cycle; mem_req drops the cycle after ack.
  - On ack: lo<=mem_rdata.
  - mem_rdata[15]=1 -> FETCH_HI; else ISSUE with instr_long=0 and hi=0.
- FETCH_HI:
  - mem_req=1, mem_addr=pc+1 (mod 2^PC_W).
  - On ack: hi<=mem_rdata -> ISSUE with instr_long=1.
- ISSUE:
  - instr_valid=1; instr_word, instr_long and instr_pc stay stable until instr_valid&instr_ready.
  - On transfer: pc += 1 (short) or 2 (long), wrapping; instr_count += 1.
  - Next state after transfer: HALT if halt_req; IDLE if !enable; else FETCH_LO.
  - Minimum issue interval: 2 cycles per short instruction with single-cycle ack.
- HALT:
  - halted=1.
  - Leaves to FETCH_LO when !halt_req & enable; to IDLE when !enable.
- halt_req during a fetch: the fetch completes and the instruction is issued; the halt takes effect after that transfer.
- Redirect:
  - IDLE, ISSUE or HALT: pc<=redirect_pc next cycle.
  - ISSUE: instr_valid drops and state -> FETCH_LO (HALT stays HALT).
  - Redirect in the same cycle as an ISSUE transfer: the transfer counts (instr_count increments), and pc<=redirect_pc, not the incremented pc.
  - FETCH_LO/FETCH_HI: the memory handshake is never abandoned. pc<=redirect_pc and flush_pending<=1. At ack, data is discarded, flush_pending<=0, next state FETCH_LO at the new pc.
  - A second redirect before ack overwrites pc; the last one wins.
- enable deasserted mid-fetch: the fetch completes and issues; the block goes to IDLE after the transfer.
- mem_ack outside FETCH_LO/FETCH_HI is ignored.

Optional Feature:
AAP_SLOW_TICK_EN
- Defined:
  - Internal divider counts 0..DIV_MAX on clock, wraps, reset to 0.
  - tick=1 when the count equals DIV_MAX.
  - State, pc and instr_count update, and mem_ack, instr_ready and redirect_valid are sampled, only on tick cycles. Partners hold their signals until sampled.
  - Outputs change only on the cycle after a tick.
- Undefined: tick is tied to 1 and there is no divider logic; behaviour is as above.

Test Plan:
- Reset release, enable=1, mem returns 0x1234 at addr 0 with ack 1 cycle after req -> instr_valid with instr_word=0x00001234, instr_long=0, instr_pc=0. After ready: next mem_addr=1, instr_count=1.
- addr 4=0x8001, addr 5=0xBEEF -> two reads at addrs 4 then 5; instr_word=0xBEEF8001, instr_long=1, instr_pc=4. Next fetch at addr 6.
- Hold instr_ready=0 for 5 cycles -> instr_word stable and instr_valid high throughout. Ready on cycle 6 -> exactly one count increment.
- Redirect to 0x0100 while mem_req is outstanding at addr 8, ack 3 cycles later -> no instr_valid for addr 8; next mem_addr=0x0100.
- pc=0xFFFF with a long instruction -> FETCH_HI at addr 0x0000; next pc=0x0001.
- halt_req during FETCH_LO -> the instruction still issues; after transfer halted=1 and no mem_req. Dropping halt_req resumes fetch at the next pc. Async reset mid-FETCH_HI -> all outputs 0 immediately, pc=RESET_PC.
